// File: rtl/regfile_access_ctrl_pkg.sv
// Shared register-id constants and helpers for the register file access controller.
// Used by regfile_access_ctrl and regacc_wb_fifo (REGACC_FORWARD_EN selects bypass).
package regfile_access_ctrl_pkg;

    typedef logic [3:0] reg_id_t;

    localparam reg_id_t REG_CMP  = 4'h9;
    localparam reg_id_t REG_SP   = 4'hA;
    localparam reg_id_t REG_SF   = 4'hB;
    localparam reg_id_t REG_PC   = 4'hC;
    localparam reg_id_t REG_NONE = 4'hF;
    localparam reg_id_t REG_LAST = 4'hC;

    function automatic logic id_dropped(reg_id_t id);
        return id > REG_LAST;
    endfunction

endpackage

// File: rtl/regacc_wb_fifo.sv
// Writeback FIFO (id + data) exposing every entry in age order for the match scan.
// Entry data is exposed only when REGACC_FORWARD_EN is defined.
module regacc_wb_fifo
    import regfile_access_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  reg_id_t                   push_id,
    input  logic [DW-1:0]             push_data,
    input  logic                      pop,
    output reg_id_t                   head_id,
    output logic [DW-1:0]             head_data,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH-1:0][3:0]     age_id,
`ifdef REGACC_FORWARD_EN
    output logic [DEPTH-1:0][DW-1:0]  age_data,
`endif
    output logic [DEPTH-1:0]          age_valid
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][3:0]    mem_id;
    logic [DEPTH-1:0][DW-1:0] mem_data;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              count;
    logic                     do_push;
    logic                     do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: validity is carried by count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_id[wr_ptr]   <= push_id;
            mem_data[wr_ptr] <= push_data;
        end
    end

    assign head_id   = mem_id[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Index 0 is the head (oldest); higher indices are younger.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_id[k]    = mem_id[rd_ptr + AW'(k)];
`ifdef REGACC_FORWARD_EN
            age_data[k]  = mem_data[rd_ptr + AW'(k)];
`endif
            age_valid[k] = ((AW+1)'(k) < count);
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Initiator side of the register file port: operand fetch plus buffered writeback.
// REGACC_FORWARD_EN: bypass youngest pending writeback; otherwise stall on id hazard.
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int WB_DEPTH = 4,
    parameter int DW       = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [3:0]    op_rs1,
    input  logic [3:0]    op_rs2,
    output logic          resp_valid,
    output logic [DW-1:0] resp_a,
    output logic [DW-1:0] resp_b,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [3:0]    wb_id,
    input  logic [DW-1:0] wb_value,
    output logic          wb_err,
    output logic [3:0]    rf_read1_id,
    input  logic [DW-1:0] rf_read1_value,
    output logic [3:0]    rf_read2_id,
    input  logic [DW-1:0] rf_read2_value,
    output logic [3:0]    rf_write_id,
    output logic [DW-1:0] rf_write_value
);

    logic                        fifo_full;
    logic                        fifo_empty;
    reg_id_t                     head_id;
    logic [DW-1:0]               head_data;
    logic [WB_DEPTH-1:0][3:0]    age_id;
    logic [WB_DEPTH-1:0]         age_valid;
    logic                        wb_fire;
    logic                        wb_push;
    logic                        op_fire;
    logic [DW-1:0]               op_a;
    logic [DW-1:0]               op_b;
`ifdef REGACC_FORWARD_EN
    logic [WB_DEPTH-1:0][DW-1:0] age_data;
`endif

    assign wb_ready = !fifo_full;
    assign wb_fire  = wb_valid && wb_ready;
    assign wb_push  = wb_fire && !id_dropped(wb_id);
    assign op_fire  = op_valid && op_ready;

    regacc_wb_fifo #(
        .DEPTH (WB_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wb_push),
        .push_id   (wb_id),
        .push_data (wb_value),
        .pop       (!fifo_empty),
        .head_id   (head_id),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .age_id    (age_id),
`ifdef REGACC_FORWARD_EN
        .age_data  (age_data),
`endif
        .age_valid (age_valid)
    );

    assign rf_read1_id    = op_rs1;
    assign rf_read2_id    = op_rs2;
    assign rf_write_id    = fifo_empty ? REG_NONE : head_id;
    assign rf_write_value = fifo_empty ? '0 : head_data;

`ifdef REGACC_FORWARD_EN
    assign op_ready = 1'b1;

    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        op_a = rf_read1_value;
        op_b = rf_read2_value;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (age_valid[k] && age_id[k] == op_rs1)
                op_a = age_data[k];
            if (age_valid[k] && age_id[k] == op_rs2)
                op_b = age_data[k];
        end
    end
`else
    logic hazard;

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (age_valid[k] && (age_id[k] == op_rs1 || age_id[k] == op_rs2))
                hazard = 1'b1;
        end
    end

    assign op_ready = !hazard;
    assign op_a     = rf_read1_value;
    assign op_b     = rf_read2_value;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_a     <= '0;
            resp_b     <= '0;
            wb_err     <= 1'b0;
        end else begin
            resp_valid <= op_fire;
            if (op_fire) begin
                resp_a <= op_a;
                resp_b <= op_b;
            end
            if (wb_fire && id_dropped(wb_id))
                wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a behavioural register file.
// Works for both builds (REGACC_FORWARD_EN defined or not).
module tb_regfile_access_ctrl;

    localparam int WB_DEPTH = 4;
    localparam int DW       = 8;
`ifdef REGACC_FORWARD_EN
    localparam int HZ_EXP = 1;
`else
    localparam int HZ_EXP = 0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_rs1;
    logic [3:0]    op_rs2;
    logic          resp_valid;
    logic [DW-1:0] resp_a;
    logic [DW-1:0] resp_b;
    logic          wb_valid;
    logic          wb_ready;
    logic [3:0]    wb_id;
    logic [DW-1:0] wb_value;
    logic          wb_err;
    logic [3:0]    rf_read1_id;
    logic [DW-1:0] rf_read1_value;
    logic [3:0]    rf_read2_id;
    logic [DW-1:0] rf_read2_value;
    logic [3:0]    rf_write_id;
    logic [DW-1:0] rf_write_value;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]      rf_m [16];
    bit                 rf_init = 0;
    logic [DW-1:0]      arch [16];
    bit                 err_m;
    logic [2*DW-1:0]    resp_q [$];
    logic [4+DW-1:0]    wr_q [$];

    regfile_access_ctrl #(
        .WB_DEPTH (WB_DEPTH),
        .DW       (DW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_rs1         (op_rs1),
        .op_rs2         (op_rs2),
        .resp_valid     (resp_valid),
        .resp_a         (resp_a),
        .resp_b         (resp_b),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_id          (wb_id),
        .wb_value       (wb_value),
        .wb_err         (wb_err),
        .rf_read1_id    (rf_read1_id),
        .rf_read1_value (rf_read1_value),
        .rf_read2_id    (rf_read2_id),
        .rf_read2_value (rf_read2_value),
        .rf_write_id    (rf_write_id),
        .rf_write_value (rf_write_value)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(int i);
        return (i > 12) ? '0 : DW'(8'h30 ^ (i * 8'h11));
    endfunction

    function automatic logic [DW-1:0] rf_peek(logic [3:0] id);
        if (id > 4'hC)
            return '0;
        return rf_init ? rf_m[id] : init_val(int'(id));
    endfunction

    // Behavioural register file: 13 entries, ids D-F read 0, F is no-write.
    always @(posedge clock) begin
        if (!rf_init) begin
            for (int i = 0; i < 16; i++)
                rf_m[i] <= init_val(i);
            rf_init <= 1'b1;
        end else if (rf_write_id <= 4'hC) begin
            rf_m[rf_write_id] <= rf_write_value;
        end
    end

    assign rf_read1_value = rf_peek(rf_read1_id);
    assign rf_read2_value = rf_peek(rf_read2_id);

    always @(negedge clock or posedge reset) begin
        if (reset) begin
            resp_q.delete();
            wr_q.delete();
            err_m = 1'b0;
            for (int i = 0; i < 16; i++)
                arch[i] = rf_peek(4'(i));
        end else begin
            logic exp_rdy;
            logic [2*DW-1:0] e;
            logic [4+DW-1:0] w;
            exp_rdy = 1'b1;
`ifndef REGACC_FORWARD_EN
            foreach (wr_q[i])
                if (wr_q[i][4+DW-1:DW] == op_rs1 || wr_q[i][4+DW-1:DW] == op_rs2)
                    exp_rdy = 1'b0;
`endif
            chk("op_ready", op_ready, exp_rdy);
            chk("wb_ready", wb_ready, wr_q.size() < WB_DEPTH);
            chk("wb_err", wb_err, err_m);
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    chk("resp_extra", 1, 0);
                end else begin
                    e = resp_q.pop_front();
                    chk("resp_a", resp_a, e[2*DW-1:DW]);
                    chk("resp_b", resp_b, e[DW-1:0]);
                end
            end
            if (rf_write_id != 4'hF) begin
                if (wr_q.size() == 0) begin
                    chk("wr_extra", {rf_write_id, rf_write_value}, 32'hF00);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_id", rf_write_id, w[4+DW-1:DW]);
                    chk("wr_val", rf_write_value, w[DW-1:0]);
                end
            end
            if (op_valid && op_ready)
                resp_q.push_back({arch[op_rs1], arch[op_rs2]});
            if (wb_valid && wb_ready) begin
                if (wb_id <= 4'hC) begin
                    arch[wb_id] = wb_value;
                    wr_q.push_back({wb_id, wb_value});
                end else begin
                    err_m = 1'b1;
                end
            end
        end
    end

    // Hold each request until its handshake completes; optional ready check on first cycle.
    task automatic step(input logic ov, input logic [3:0] r1, input logic [3:0] r2,
                        input logic wv, input logic [3:0] id, input logic [DW-1:0] val,
                        input int hz);
        logic opa, wba;
        op_valid = ov; op_rs1 = r1; op_rs2 = r2;
        wb_valid = wv; wb_id = id; wb_value = val;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (k == 0 && hz >= 0)
                chk("op_ready_hz", op_ready, hz);
            opa = op_valid && op_ready;
            wba = wb_valid && wb_ready;
            @(posedge clock); #1;
            if (opa) op_valid = 1'b0;
            if (wba) wb_valid = 1'b0;
            if (!op_valid && !wb_valid)
                break;
        end
        if (op_valid || wb_valid)
            chk("hs_timeout", 1, 0);
        op_valid = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        op_valid = 0; op_rs1 = 0; op_rs2 = 0;
        wb_valid = 0; wb_id = 0; wb_value = 0;
        idle(3);
        reset = 1'b0;
        chk("rst_wr_id", rf_write_id, 4'hF);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_a", resp_a, 0);
        chk("rst_wb_ready", wb_ready, 1);
        chk("rst_wb_err", wb_err, 0);
        idle(1);

        step(0, 0, 0, 1, 4'h2, 8'h5A, -1);
        step(1, 4'h2, 4'h3, 0, 0, 0, HZ_EXP);
        idle(2);

        step(0, 0, 0, 1, 4'h4, 8'h11, -1);
        step(0, 0, 0, 1, 4'h4, 8'h22, -1);
        step(1, 4'h4, 4'h4, 0, 0, 0, HZ_EXP);
        idle(2);

        step(1, 4'h5, 4'h5, 1, 4'h5, 8'h99, -1);
        step(1, 4'h5, 4'h1, 0, 0, 0, -1);
        idle(2);

        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 1, 4'(i + 6), 8'(8'h40 + i), -1);
        step(1, 4'h6, 4'hA, 0, 0, 0, -1);
        idle(2);

        step(0, 0, 0, 1, 4'hC, 8'hC3, -1);
        step(1, 4'hC, 4'hD, 0, 0, 0, -1);
        step(1, 4'hE, 4'hF, 0, 0, 0, -1);
        step(0, 0, 0, 1, 4'hE, 8'h77, -1);
        idle(3);
        chk("wb_err_set", wb_err, 1);

        step(0, 0, 0, 1, 4'h1, 8'hA1, -1);
        step(0, 0, 0, 1, 4'h2, 8'hA2, -1);
        step(0, 0, 0, 1, 4'h3, 8'hA3, -1);
        op_valid = 1; op_rs1 = 4'h1; op_rs2 = 4'h2;
        wb_valid = 1; wb_id = 4'h7; wb_value = 8'hAB;
        @(posedge clock); #1;
        op_valid = 0; wb_valid = 0;
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_id", rf_write_id, 4'hF);
        chk("mid_rst_resp_valid", resp_valid, 0);
        @(negedge clock);
        chk("mid_rst_wb_ready", wb_ready, 1);
        chk("mid_rst_wb_err", wb_err, 0);
        chk("mid_rst_wr_id2", rf_write_id, 4'hF);
        @(posedge clock); #1;
        reset = 1'b0;
        step(1, 4'h7, 4'h3, 0, 0, 0, -1);
        idle(2);

        for (int c = 0; c < 400; c++) begin
            op_valid = 1'($urandom_range(0, 1));
            op_rs1   = 4'($urandom_range(0, 15));
            op_rs2   = 4'($urandom_range(0, 15));
            wb_valid = 1'($urandom_range(0, 1));
            wb_id    = 4'($urandom_range(0, 15));
            wb_value = 8'($urandom);
            @(posedge clock); #1;
        end
        op_valid = 0;
        wb_valid = 0;
        idle(5);
        chk("resp_q_empty", resp_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("wb_err_end", wb_err, err_m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
